// File: rtl/lincoln_wb_uart_tx_if.sv
// lincoln_wb_uart_tx_if: Wishbone classic slave bus bundle for the UART transmitter
interface lincoln_wb_uart_tx_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
                  input  wbs_ack_o, wbs_dat_o);
  modport slave  (input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
                  output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/lincoln_wb_uart_tx.sv
// lincoln_wb_uart_tx: Wishbone-slave 8N1 UART transmitter with byte FIFO, status/baud/control registers and done IRQ
module lincoln_wb_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  lincoln_wb_uart_tx_if.slave        wb,
  output logic                       tx_o,
  output logic                       tx_oeb,
  output logic                       irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state, state_n;
  logic        ack, ovf, irq;
  logic [31:0] dat_o, rdata, status;
  logic [15:0] div, div_lat, cnt, eff;
  logic [1:0]  ctrl, ofs;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic hit, req, wr, wr_data, wr_stat, wr_div, wr_ctrl;
  logic full, empty, push, pop, busy, tick, load;
  logic unused_bits;
  assign unused_bits = ^{wb.wbs_sel_i[3:2], wb.wbs_dat_i[31:16], wb.wbs_adr_i[1:0]};
  assign hit     = wb.wbs_adr_i[31:4] == BASE_ADDR[31:4];
  assign req     = wb.wbs_cyc_i & wb.wbs_stb_i & hit & !ack;
  // writes commit on the edge that closes the ack cycle, while the master still holds the request
  assign wr      = ack & wb.wbs_cyc_i & wb.wbs_stb_i & wb.wbs_we_i & hit;
  assign ofs     = wb.wbs_adr_i[3:2];
  assign wr_data = wr & (ofs == 2'd0) & wb.wbs_sel_i[0];
  assign wr_stat = wr & (ofs == 2'd1) & wb.wbs_sel_i[0];
  assign wr_div  = wr & (ofs == 2'd2);
  assign wr_ctrl = wr & (ofs == 2'd3) & wb.wbs_sel_i[0];
  assign full    = level == LW'(FIFO_DEPTH);
  assign empty   = level == '0;
  assign push    = wr_data & !full;
  assign pop     = load;
  assign busy    = state != IDLE;
  assign tick    = cnt == '0;
  assign eff     = div < 16'd2 ? 16'd2 : div;
  assign status  = {19'b0, 5'(level), 4'b0, ovf, empty, full, busy};
  assign rdata   = ofs == 2'd1 ? status : ofs == 2'd2 ? {16'b0, div} : ofs == 2'd3 ? {30'b0, ctrl} : '0;
  assign wb.wbs_ack_o = ack;
  assign wb.wbs_dat_o = dat_o;
  assign irq_o   = irq;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack   <= 1'b0;
      dat_o <= '0;
      div   <= DEFAULT_DIV;
      ctrl  <= '0;
      ovf   <= 1'b0;
      irq   <= 1'b0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      ack   <= req;
      dat_o <= req ? rdata : '0;
      if (wr_div & wb.wbs_sel_i[0]) div[7:0] <= wb.wbs_dat_i[7:0];
      if (wr_div & wb.wbs_sel_i[1]) div[15:8] <= wb.wbs_dat_i[15:8];
      if (wr_ctrl) ctrl <= wb.wbs_dat_i[1:0];
      ovf   <= (wr_data & full) | (ovf & !(wr_stat & wb.wbs_dat_i[3]));
      irq   <= ctrl[1] & empty & !busy;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wptr] <= wb.wbs_dat_i[7:0];
  end
  always_ff @(posedge wb_clk_i) begin
    state <= wb_rst_i ? IDLE : state_n;
  end
  always_comb begin
    load    = (state == IDLE || (state == STOP && tick)) && ctrl[0] && !empty;
    state_n = load ? START :
              state == IDLE || !tick ? state :
              state == START ? DATA :
              state == DATA ? (bit_idx == 3'd7 ? STOP : DATA) : IDLE;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      div_lat <= 16'd2;
    end else if (load) begin
      shreg   <= mem[rptr];
      div_lat <= eff;
      cnt     <= eff - 16'd1;
      bit_idx <= '0;
    end else if (busy) begin
      cnt <= tick ? div_lat - 16'd1 : cnt - 16'd1;
      if (tick && state == DATA) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= shreg >> 1;
      end
    end
  end
  always_comb begin
    tx_o   = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
    tx_oeb = ~(ctrl[0] | busy);
  end
endmodule
